// File: rtl/ct_spsram_param_shadow.sv
// Parametrised single-port SRAM with a per-bit taint shadow array, a 0/1-stage read
// pipeline, a lane-granular write mask and a post-reset zero-fill sweep.

module ct_spsram_shadow_lane #(
  parameter int LW = 1
) (
  input  logic          wr_i,
  input  logic          lane_t_i,
  input  logic [LW-1:0] old_t_i,
  input  logic [LW-1:0] d_t_i,
  output logic [LW-1:0] new_t_o
);
  // Any taint on control or on this lane's enable poisons the whole lane.
  assign new_t_o = (wr_i ? d_t_i : old_t_i) | {LW{lane_t_i}};
endmodule

module ct_spsram_param_shadow #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 128,
  parameter int WE_WIDTH   = 128,
  parameter int RD_PIPE    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [WE_WIDTH-1:0]   WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  init_busy
);
  localparam int LW    = DATA_WIDTH / WE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT, S_RUN} state_e;
  typedef logic [WE_WIDTH-1:0][LW-1:0] word_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  word_t data_mem   [DEPTH];
  word_t shadow_mem [DEPTH];

  word_t d_l, dt_l, sh_old, sh_new;
  logic  run, ctrl_t, rd_en, pw, wr_any;

  assign d_l  = D;
  assign dt_l = D_t0;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q <= (INIT_EN != 0) ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_RUN;
    end
  end

  assign init_busy = (INIT_EN != 0) && (!cpurst_b || state_q == S_INIT);

  assign run    = (state_q == S_RUN);
  assign ctrl_t = CEN_t0 | GWEN_t0 | (|A_t0);
  // A tainted CEN may or may not have fired, so the read/write paths treat it as possible.
  assign rd_en  = run & (~CEN | CEN_t0) & GWEN;
  assign pw     = run & (~CEN | CEN_t0) & (~GWEN | GWEN_t0);
  assign wr_any = run & ~CEN & ~GWEN;
  assign sh_old = shadow_mem[A];

  for (genvar i = 0; i < WE_WIDTH; i++) begin : g_lane
    ct_spsram_shadow_lane #(.LW(LW)) u_lane (
      .wr_i     (wr_any & ~WEN[i]),
      .lane_t_i (ctrl_t | WEN_t0[i]),
      .old_t_i  (sh_old[i]),
      .d_t_i    (dt_l[i]),
      .new_t_o  (sh_new[i])
    );
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b) begin
      if (!run) begin
        data_mem[cnt_q]   <= '0;
        shadow_mem[cnt_q] <= '0;
      end else begin
        for (int i = 0; i < WE_WIDTH; i++)
          if (wr_any && !WEN[i]) data_mem[A][i] <= d_l[i];
        if (pw) shadow_mem[A] <= sh_new;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_data, rd_taint, q_q, qt_q;
  assign rd_data  = data_mem[A];
  assign rd_taint = shadow_mem[A] | {DATA_WIDTH{ctrl_t}};

  if (RD_PIPE == 0) begin : g_pipe0
    always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
        q_q  <= '0;
        qt_q <= '0;
      end else if (rd_en) begin
        q_q  <= rd_data;
        qt_q <= rd_taint;
      end
    end
  end else begin : g_pipe1
    logic [DATA_WIDTH-1:0] s1_q, s1t_q;
    logic [1:0]            vld_pipe;
    assign vld_pipe[0] = rd_en;
    always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
        s1_q        <= '0;
        s1t_q       <= '0;
        vld_pipe[1] <= 1'b0;
        q_q         <= '0;
        qt_q        <= '0;
      end else begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) begin
          s1_q  <= rd_data;
          s1t_q <= rd_taint;
        end
        if (vld_pipe[1]) begin
          q_q  <= s1_q;
          qt_q <= s1t_q;
        end
      end
    end
  end

  assign Q    = q_q;
  assign Q_t0 = qt_q;
endmodule

// File: tb/tb_ct_spsram_param_shadow.sv
// Directed bench: two instances (RD_PIPE=0 and RD_PIPE=1) share one stimulus stream.

module tb_ct_spsram_param_shadow;
  localparam int AW = 4, DW = 16, WW = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [AW-1:0] a, a_t;
  logic          cen, cen_t, gwen, gwen_t;
  logic [WW-1:0] wen, wen_t;
  logic [DW-1:0] d, d_t;
  logic [DW-1:0] q0, qt0, q1, qt1;
  logic          busy0, busy1;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  always #5 clk = ~clk;

  ct_spsram_param_shadow #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
                           .RD_PIPE(0), .INIT_EN(1)) u_dut (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .A(a), .A_t0(a_t), .CEN(cen), .CEN_t0(cen_t),
    .GWEN(gwen), .GWEN_t0(gwen_t), .WEN(wen), .WEN_t0(wen_t), .D(d), .D_t0(d_t),
    .Q(q0), .Q_t0(qt0), .init_busy(busy0));

  ct_spsram_param_shadow #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
                           .RD_PIPE(1), .INIT_EN(1)) u_dut_p (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .A(a), .A_t0(a_t), .CEN(cen), .CEN_t0(cen_t),
    .GWEN(gwen), .GWEN_t0(gwen_t), .WEN(wen), .WEN_t0(wen_t), .D(d), .D_t0(d_t),
    .Q(q1), .Q_t0(qt1), .init_busy(busy1));

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cen = 1'b1; cen_t = 1'b0; gwen = 1'b1; gwen_t = 1'b0;
    a = '0; a_t = '0; wen = '1; wen_t = '0; d = '0; d_t = '0;
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dd,
                    input logic [DW-1:0] dt, input logic [WW-1:0] we);
    idle();
    cen = 1'b0; gwen = 1'b0; a = ad; d = dd; d_t = dt; wen = we;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] ad, input logic [AW-1:0] at);
    idle();
    cen = 1'b0; a = ad; a_t = at;
    cyc();
    idle();
  endtask

  // Counts edges until init_busy drops; bounded so a stuck sweep still terminates.
  task automatic sweep(output int cnt);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      cnt++;
      if (!busy0) break;
    end
  endtask

  initial begin
    idle();
    rst_b = 1'b0;
    cyc(); cyc();
    chk("rst_busy", {15'd0, busy0}, 16'd1);
    chk("rst_q", q0, 16'h0000);
    chk("rst_qt", qt0, 16'h0000);

    // 1: sweep length and zeroed contents
    rst_b = 1'b1;
    sweep(n);
    chk("sweep_len", 16'(n), 16'd16);
    rd(4'd3, 4'h0);
    chk("t1_q", q0, 16'h0000);
    chk("t1_qt", qt0, 16'h0000);

    // 2: lane-masked write
    wr(4'd5, 16'hA5C3, 16'h0000, 2'b10);
    rd(4'd5, 4'h0);
    chk("t2_q", q0, 16'h00C3);
    chk("t2_qt", qt0, 16'h0000);

    // 3: data taint, no write-through, address-taint read, CEN-taint read
    wr(4'd2, 16'h1234, 16'h000F, 2'b00);
    chk("t3_nowt", q0, 16'h00C3);
    rd(4'd2, 4'h0);
    chk("t3_q", q0, 16'h1234);
    chk("t3_qt", qt0, 16'h000F);
    rd(4'd2, 4'h1);
    chk("t3_at_q", q0, 16'h1234);
    chk("t3_at_qt", qt0, 16'hFFFF);
    idle(); cen_t = 1'b1; a = 4'd5;
    cyc(); idle();
    chk("t3_cent_q", q0, 16'h00C3);
    chk("t3_cent_qt", qt0, 16'hFFFF);
    cyc();
    chk("t3_hold_q", q0, 16'h00C3);

    // 4: masked write with tainted lane enable
    idle(); cen = 1'b0; gwen = 1'b0; a = 4'd2; d = 16'hFFFF; wen = 2'b11; wen_t = 2'b10;
    cyc(); idle();
    rd(4'd2, 4'h0);
    chk("t4_q", q0, 16'h1234);
    chk("t4_qt", qt0, 16'hFF0F);

    // 5: reset in RUN, then reset mid-sweep at cnt=7
    rst_b = 1'b0;
    cyc();
    chk("t5_rst_q", q0, 16'h0000);
    chk("t5_rst_qt", qt0, 16'h0000);
    rst_b = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk("t5_busy_mid", {15'd0, busy0}, 16'd1);
    rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    sweep(n);
    chk("t5_sweep_len", 16'(n), 16'd16);
    rd(4'd2, 4'h0);
    chk("t5_q2", q0, 16'h0000);
    chk("t5_qt2", qt0, 16'h0000);
    rd(4'd5, 4'h0);
    chk("t5_q5", q0, 16'h0000);

    // 6: RD_PIPE=1 latency and hold
    wr(4'd5, 16'hA5C3, 16'h0000, 2'b10);
    rd(4'd5, 4'h0);
    chk("t6_p0_q", q0, 16'h00C3);
    chk("t6_p1_early", q1, 16'h0000);
    cyc();
    chk("t6_p1_q", q1, 16'h00C3);
    chk("t6_p1_qt", qt1, 16'h0000);
    cyc(); cyc();
    chk("t6_p1_hold", q1, 16'h00C3);
    chk("t6_p0_hold", q0, 16'h00C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
